// File: rtl/gcd_job_sequencer_if.sv
// Stream and core-side signals of the GCD job sequencer, bundled in one interface.
// The slave modport is the sequencer's view. The master modport is the view of
// its environment: the upstream feeder, the GCD core and the result consumer.
interface gcd_job_sequencer_if #(
    parameter int unsigned number_width = 16,
    parameter int unsigned CNT_WIDTH    = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic [number_width-1:0] in_A;
    logic [number_width-1:0] in_B;
    logic                    gcd_start;
    logic [number_width-1:0] core_A;
    logic [number_width-1:0] core_B;
    logic [number_width-1:0] core_res;
    logic                    core_done;
    logic                    out_valid;
    logic                    out_ready;
    logic [number_width-1:0] out_res;
    logic                    out_err;
    logic [CNT_WIDTH-1:0]    jobs_done;

    modport slave (
        input  in_valid, in_A, in_B, core_res, core_done, out_ready,
        output in_ready, gcd_start, core_A, core_B, out_valid, out_res, out_err, jobs_done
    );

    modport master (
        output in_valid, in_A, in_B, core_res, core_done, out_ready,
        input  in_ready, gcd_start, core_A, core_B, out_valid, out_res, out_err, jobs_done
    );
endinterface

// File: rtl/gcd_job_sequencer.sv
// Feeds operand pairs to the GCD core one job at a time and returns the results.
// Zero-operand pairs are resolved locally without starting the core. A watchdog
// aborts any job that waits too long for the core.
module gcd_job_sequencer #(
    parameter int unsigned number_width   = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                clk,
    input  logic                rst,
    gcd_job_sequencer_if.slave  bus
);
    localparam int unsigned WdWidth = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StLaunch, StWait, StOut} state_e;

    state_e                  state_q;
    logic                    in_ready_q;
    logic [number_width-1:0] core_a_q;
    logic [number_width-1:0] core_b_q;
    logic                    out_valid_q;
    logic [number_width-1:0] out_res_q;
    logic                    out_err_q;
    logic [CNT_WIDTH-1:0]    jobs_done_q;
    logic [WdWidth-1:0]      wdog_q;

    // Job FSM with all outputs registered. wdog_q == 0 marks the first WAIT
    // cycle, in which core_done may still be left over from the previous job.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            in_ready_q  <= 1'b0;
            core_a_q    <= '0;
            core_b_q    <= '0;
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_err_q   <= 1'b0;
            jobs_done_q <= '0;
            wdog_q      <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    in_ready_q <= 1'b1;
                    if (bus.in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        if (bus.in_A == '0 || bus.in_B == '0) begin
                            out_res_q   <= bus.in_A | bus.in_B;
                            out_err_q   <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= StOut;
                        end else begin
                            core_a_q <= bus.in_A;
                            core_b_q <= bus.in_B;
                            state_q  <= StLaunch;
                        end
                    end
                end
                StLaunch: begin
                    wdog_q  <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    wdog_q <= wdog_q + WdWidth'(1);
                    // A done from the core beats a timeout in the same cycle.
                    if (wdog_q != '0 && bus.core_done) begin
                        out_res_q   <= bus.core_res;
                        out_err_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= StOut;
                    end else if (wdog_q == WdWidth'(TIMEOUT_CYCLES - 1)) begin
                        out_res_q   <= '0;
                        out_err_q   <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= StOut;
                    end
                end
                StOut: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        jobs_done_q <= jobs_done_q + CNT_WIDTH'(1);
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // The launch pulse lasts exactly one cycle because LAUNCH always moves on.
    always_comb begin
        bus.gcd_start = (state_q == StLaunch);
        bus.in_ready  = in_ready_q;
        bus.core_A    = core_a_q;
        bus.core_B    = core_b_q;
        bus.out_valid = out_valid_q;
        bus.out_res   = out_res_q;
        bus.out_err   = out_err_q;
        bus.jobs_done = jobs_done_q;
    end
endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Directed bench for gcd_job_sequencer. The bench drives the core-side signals
// itself, which lets each scenario control done timing and stale-done cases exactly.
module tb_gcd_job_sequencer;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    int   starts;

    gcd_job_sequencer_if #(.number_width(16), .CNT_WIDTH(16)) bus ();

    gcd_job_sequencer #(
        .number_width  (16),
        .TIMEOUT_CYCLES(8),
        .CNT_WIDTH     (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle. The bench samples and drives 1 time unit after the rising edge.
    // Each cycle with gcd_start high is counted.
    task automatic tick();
        if (bus.gcd_start) starts++;
        @(posedge clk);
        #1;
    endtask

    // Offer a pair and wait, with a bound, for it to be accepted.
    task automatic send(input logic [15:0] a, input logic [15:0] b);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_A     = a;
        bus.in_B     = b;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL send_accept: in_ready=%b required 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        vectors++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.gcd_start !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b start=%b required 0 0 0",
                     bus.in_ready, bus.out_valid, bus.gcd_start);
        end
        vectors++;
        if (bus.out_res !== 16'd0 || bus.out_err !== 1'b0 || bus.jobs_done !== 16'd0 ||
            bus.core_A !== 16'd0 || bus.core_B !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_data: res=%0d err=%b jobs=%0d A=%0d B=%0d required all 0",
                     bus.out_res, bus.out_err, bus.jobs_done, bus.core_A, bus.core_B);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_idle_ready: in_ready=%b required 1", bus.in_ready);
        end
    endtask

    task automatic test_core_job();
        starts = 0;
        send(16'd48, 16'd18);
        tick();
        repeat (4) tick();
        bus.core_done = 1'b1;
        bus.core_res  = 16'd6;
        vectors++;
        if (bus.core_A !== 16'd48 || bus.core_B !== 16'd18 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL core_hold: A=%0d B=%0d out_valid=%b required 48 18 0",
                     bus.core_A, bus.core_B, bus.out_valid);
        end
        tick();
        bus.core_done = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_res !== 16'd6 || bus.out_err !== 1'b0 ||
            bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL core_result: valid=%b res=%0d err=%b in_ready=%b required 1 6 0 0",
                     bus.out_valid, bus.out_res, bus.out_err, bus.in_ready);
        end
        consume();
        vectors++;
        if (starts != 1 || bus.jobs_done !== 16'd1 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL core_finish: starts=%0d jobs=%0d in_ready=%b required 1 1 1",
                     starts, bus.jobs_done, bus.in_ready);
        end
    endtask

    task automatic test_zero_bypass();
        starts = 0;
        send(16'd0, 16'd35);
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_res !== 16'd35 || bus.out_err !== 1'b0) begin
            miscompares++;
            $display("FAIL bypass_0_35: valid=%b res=%0d err=%b required 1 35 0",
                     bus.out_valid, bus.out_res, bus.out_err);
        end
        consume();
        send(16'd0, 16'd0);
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_res !== 16'd0) begin
            miscompares++;
            $display("FAIL bypass_0_0: valid=%b res=%0d required 1 0", bus.out_valid, bus.out_res);
        end
        consume();
        vectors++;
        if (starts != 0 || bus.jobs_done !== 16'd3) begin
            miscompares++;
            $display("FAIL bypass_no_start: starts=%0d jobs=%0d required 0 3", starts, bus.jobs_done);
        end
    endtask

    task automatic test_stale_done();
        bus.core_done = 1'b1;
        bus.core_res  = 16'd99;
        send(16'd12, 16'd8);
        tick();
        tick();
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stale_ignored: out_valid=%b required 0", bus.out_valid);
        end
        bus.core_done = 1'b0;
        tick();
        bus.core_done = 1'b1;
        bus.core_res  = 16'd4;
        tick();
        bus.core_done = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_res !== 16'd4) begin
            miscompares++;
            $display("FAIL stale_new_done: valid=%b res=%0d required 1 4", bus.out_valid, bus.out_res);
        end
        consume();
        vectors++;
        if (bus.jobs_done !== 16'd4) begin
            miscompares++;
            $display("FAIL stale_jobs: jobs=%0d required 4", bus.jobs_done);
        end
    endtask

    task automatic test_timeout();
        send(16'd7, 16'd5);
        tick();
        repeat (7) tick();
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_early: out_valid=%b required 0 after 7 wait cycles", bus.out_valid);
        end
        tick();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_err !== 1'b1 || bus.out_res !== 16'd0) begin
            miscompares++;
            $display("FAIL timeout_result: valid=%b err=%b res=%0d required 1 1 0",
                     bus.out_valid, bus.out_err, bus.out_res);
        end
        consume();
        send(16'd9, 16'd6);
        tick();
        tick();
        bus.core_done = 1'b1;
        bus.core_res  = 16'd3;
        tick();
        bus.core_done = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_err !== 1'b0 || bus.out_res !== 16'd3) begin
            miscompares++;
            $display("FAIL timeout_next_job: valid=%b err=%b res=%0d required 1 0 3",
                     bus.out_valid, bus.out_err, bus.out_res);
        end
        consume();
    endtask

    task automatic test_backpressure();
        send(16'd0, 16'd5);
        bus.in_valid = 1'b1;
        bus.in_A     = 16'd3;
        bus.in_B     = 16'd0;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_res !== 16'd5 || bus.out_err !== 1'b0 ||
                bus.in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_%0d: valid=%b res=%0d err=%b in_ready=%b required 1 5 0 0",
                         i, bus.out_valid, bus.out_res, bus.out_err, bus.in_ready);
            end
        end
        bus.in_valid = 1'b0;
        consume();
        vectors++;
        if (bus.jobs_done !== 16'd7 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_release: jobs=%0d in_ready=%b valid=%b required 7 1 0",
                     bus.jobs_done, bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_async_reset();
        send(16'd30, 16'd12);
        tick();
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.gcd_start !== 1'b0 ||
            bus.jobs_done !== 16'd0 || bus.core_A !== 16'd0 || bus.out_res !== 16'd0) begin
            miscompares++;
            $display("FAIL async_reset: rdy=%b val=%b st=%b jobs=%0d A=%0d res=%0d required all 0",
                     bus.in_ready, bus.out_valid, bus.gcd_start, bus.jobs_done, bus.core_A,
                     bus.out_res);
        end
        tick();
        rst = 1'b0;
        tick();
        send(16'd21, 16'd14);
        tick();
        tick();
        bus.core_done = 1'b1;
        bus.core_res  = 16'd7;
        tick();
        bus.core_done = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_res !== 16'd7 || bus.jobs_done !== 16'd0) begin
            miscompares++;
            $display("FAIL post_reset_job: valid=%b res=%0d jobs=%0d required 1 7 0",
                     bus.out_valid, bus.out_res, bus.jobs_done);
        end
        consume();
        vectors++;
        if (bus.jobs_done !== 16'd1) begin
            miscompares++;
            $display("FAIL post_reset_jobs: jobs=%0d required 1", bus.jobs_done);
        end
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        starts        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_A      = '0;
        bus.in_B      = '0;
        bus.core_res  = '0;
        bus.core_done = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_core_job();
        test_zero_bypass();
        test_stale_done();
        test_timeout();
        test_backpressure();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
